// File: rtl/hs_pkg.sv
// Shared definitions for the hs_tx valid/ready transmit slice: bus width,
// FSM state encoding and FIFO pointer sizing.
`timescale 1ns/1ps
package hs_pkg;

  localparam int HS_DW = 16;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_SEND = 1'b1
  } hs_state_e;

  // Pointer index width for a FIFO of the given depth; level/pointers add one wrap bit.
  function automatic int hs_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/hs_tx_if.sv
// Valid/ready bus between hs_tx (master) and the downstream receiver (slave).
`timescale 1ns/1ps
interface hs_tx_if
  import hs_pkg::*;
#(
  parameter int DW = HS_DW
);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hs_fifo.sv
// Show-ahead FIFO for hs_tx: head is always mem[rd_ptr]; pushes while full are
// dropped and latched in a sticky overflow flag.
`timescale 1ns/1ps
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DW    = HS_DW,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DW-1:0]             din,
  input  logic                      pop,
  output logic [DW-1:0]             head,
  output logic                      full,
  output logic                      empty,
  output logic [hs_ptr_w(DEPTH):0]  level,
  output logic                      ovf
);
  localparam int PW = hs_ptr_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  // Extra MSB distinguishes full from empty when the index bits coincide.
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && full)
        ovf <= 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/hs_tx.sv
// Transmit end of the valid/ready bus: FIFO-buffered words presented and held until accepted.
// Optional HS_TX_TIMEOUT_EN discards a word that waits TIMEOUT cycles with ready low.
`timescale 1ns/1ps
module hs_tx
  import hs_pkg::*;
#(
  parameter int DW      = HS_DW,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DW-1:0]             wr_data,
  output logic                      full,
  output logic [hs_ptr_w(DEPTH):0]  level,
  output logic                      ovf,
  hs_tx_if.master                   bus,
  output logic                      sent,
  output logic                      timeout
);
  hs_state_e     state_q, state_nxt;
  logic [DW-1:0] head;
  logic          empty;
  logic          load;
  logic          sent_d, to_d;
  logic          valid_q, sent_q, to_q;
  logic [DW-1:0] data_q;
  logic          expire;

  hs_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (load),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level),
    .ovf   (ovf)
  );

`ifdef HS_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q;

  assign expire = (cnt_q == CW'(TIMEOUT - 1));

  // Counts edges spent in SEND with ready low since the current word was loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= '0;
    else if (state_q == HS_SEND && !bus.ready && !expire)
      cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    sent_d    = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = HS_SEND;
        end
      end
      HS_SEND: begin
        // ready on the expiry edge takes priority over the timeout.
        if (bus.ready) begin
          sent_d = 1'b1;
          if (!empty)
            load = 1'b1;
          else
            state_nxt = HS_IDLE;
        end else if (expire) begin
          to_d      = 1'b1;
          state_nxt = HS_IDLE;
        end
      end
      default: state_nxt = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HS_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      sent_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      valid_q <= (state_nxt == HS_SEND);
      sent_q  <= sent_d;
      to_q    <= to_d;
      if (load)
        data_q <= head;
    end
  end

  assign bus.valid = valid_q;
  assign bus.data  = data_q;
  assign sent      = sent_q;
  assign timeout   = to_q;

endmodule
